// File: rtl/ifm_pingpong_buf.sv
// rtl/ifm_pingpong_buf.sv - two-bank input feature map ping-pong buffer
module ifm_pingpong_buf #(
   parameter int CH    = 9,
   parameter int DW    = 8,
   parameter int DEPTH = 912,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             CK,
   input  logic             RSTn,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [AW-1:0]    wr_addr,
   input  logic [CH*DW-1:0] wr_data,
   input  logic [CH-1:0]    wr_be,
   input  logic             wr_last,
   input  logic             rd_req,
   input  logic [AW-1:0]    rd_addr,
   output logic             rd_avail,
   input  logic             rd_done,
   output logic             rd_valid,
   output logic [CH*DW-1:0] rd_data,
   output logic [1:0]       bank_full,
   output logic             addr_err
);

   localparam int          W       = CH * DW;
   // One extra bit so the bound is representable even when DEPTH == 2**AW.
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   // Storage is deliberately never reset; only control state is.
   logic [W-1:0] mem_q [0:1][0:DEPTH-1];

   logic         wsel_q, wsel_d;
   logic         rsel_q, rsel_d;
   logic [1:0]   full_q, full_d;
   logic         addr_err_q, addr_err_d;
   logic         s1_valid_q, s1_valid_d;
   logic [W-1:0] s1_data_q, s1_data_d;
   logic         rd_valid_q, rd_valid_d;
   logic [W-1:0] rd_data_q, rd_data_d;

   logic         wr_fire, rd_fire, rel_fire;
   logic         wr_in_range, rd_in_range;
   logic [W-1:0] mem_rd_word;

   assign wr_ready    = ~full_q[wsel_q];
   assign rd_avail    = full_q[rsel_q];
   assign wr_fire     = wr_valid & wr_ready;
   assign rd_fire     = rd_req & rd_avail;
   assign rel_fire    = rd_done & rd_avail;
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign bank_full = full_q;
   assign addr_err  = addr_err_q;

   // Drain-bank lookup; out-of-range addresses read as zero.
   always_comb begin
      mem_rd_word = '0;
      if (rd_in_range) begin
         mem_rd_word = mem_q[rsel_q][rd_addr];
      end
   end

   // Next-state for bank selects, full flags, error flag and read pipeline.
   always_comb begin
      wsel_d     = wsel_q;
      rsel_d     = rsel_q;
      full_d     = full_q;
      addr_err_d = addr_err_q;
      s1_valid_d = rd_fire;
      s1_data_d  = s1_data_q;
      rd_valid_d = s1_valid_q;
      rd_data_d  = rd_data_q;

      // Fill completion and release always target different banks, so both
      // can be applied in the same cycle without conflict.
      if (wr_fire && wr_last) begin
         full_d[wsel_q] = 1'b1;
         wsel_d         = ~wsel_q;
      end
      if (rel_fire) begin
         full_d[rsel_q] = 1'b0;
         rsel_d         = ~rsel_q;
      end

      if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) begin
         addr_err_d = 1'b1;
      end

      // A read issued alongside rd_done samples the bank being released.
      if (rd_fire) begin
         s1_data_d = mem_rd_word;
      end
      if (s1_valid_q) begin
         rd_data_d = s1_data_q;
      end
   end

   // Control and read-pipeline registers.
   always_ff @(posedge CK or negedge RSTn) begin
      if (!RSTn) begin
         wsel_q     <= 1'b0;
         rsel_q     <= 1'b0;
         full_q     <= 2'b00;
         addr_err_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wsel_q     <= wsel_d;
         rsel_q     <= rsel_d;
         full_q     <= full_d;
         addr_err_q <= addr_err_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Lane-masked write into the fill bank; out-of-range writes are dropped.
   always_ff @(posedge CK) begin
      if (wr_fire && wr_in_range) begin
         for (int i = 0; i < CH; i++) begin
            if (wr_be[i]) begin
               mem_q[wsel_q][wr_addr][i*DW +: DW] <= wr_data[i*DW +: DW];
            end
         end
      end
   end

endmodule

// File: tb/tb_ifm_pingpong_buf.sv
// tb/tb_ifm_pingpong_buf.sv - directed self-checking bench for ifm_pingpong_buf
module tb_ifm_pingpong_buf;

   localparam int CH    = 9;
   localparam int DW    = 8;
   localparam int DEPTH = 912;
   localparam int AW    = 10;
   localparam int W     = CH * DW;

   logic          CK;
   logic          RSTn;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [CH-1:0] wr_be;
   logic          wr_last;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_avail;
   logic          rd_done;
   logic          rd_valid;
   logic [W-1:0]  rd_data;
   logic [1:0]    bank_full;
   logic          addr_err;

   int total = 0;
   int bad   = 0;

   ifm_pingpong_buf #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .CK(CK), .RSTn(RSTn),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .wr_last(wr_last),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_avail(rd_avail),
      .rd_done(rd_done), .rd_valid(rd_valid), .rd_data(rd_data),
      .bank_full(bank_full), .addr_err(addr_err)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   function automatic logic [W-1:0] rep(input logic [7:0] b);
      rep = {CH{b}};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                           input logic [CH-1:0] be, input logic last);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be; wr_last = last;
      tick();
      wr_valid = 1'b0; wr_last = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_ready"},  W'(wr_ready),  W'(1));
      chk({tag, "_rd_avail"},  W'(rd_avail),  W'(0));
      chk({tag, "_bank_full"}, W'(bank_full), W'(0));
      chk({tag, "_rd_valid"},  W'(rd_valid),  W'(0));
      chk({tag, "_rd_data"},   rd_data,       W'(0));
      chk({tag, "_addr_err"},  W'(addr_err),  W'(0));
   endtask

   initial begin
      RSTn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      wr_last = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_done = 1'b0;
      #2;
      check_reset_outputs("reset");
      tick();
      RSTn = 1'b1;
      tick();

      // Bank 0: addr 5 masked overwrite, addr 4 zero-enable write, then 0..3.
      do_write(10'd5, rep(8'hFF), 9'h1FF, 1'b0);
      do_write(10'd5, '0, 9'b000000101, 1'b0);
      do_write(10'd4, rep(8'hFF), 9'h1FF, 1'b0);
      do_write(10'd4, '0, 9'h000, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("fill0_wr_ready", W'(wr_ready), W'(1));
         do_write(AW'(k), rep(8'(k)), 9'h1FF, k == 3);
      end
      chk("fill0_bank_full", W'(bank_full), W'(2'b01));
      chk("fill0_rd_avail",  W'(rd_avail),  W'(1));
      chk("fill0_wr_ready",  W'(wr_ready),  W'(1));

      // Single read, addr 2: two-cycle latency, data held afterwards.
      rd_req = 1'b1; rd_addr = 10'd2;
      tick();
      rd_req = 1'b0;
      chk("rd2_lat1_valid", W'(rd_valid), W'(0));
      tick();
      chk("rd2_valid", W'(rd_valid), W'(1));
      chk("rd2_data",  rd_data, rep(8'h02));
      tick();
      chk("rd2_after_valid", W'(rd_valid), W'(0));
      chk("rd2_hold_data",   rd_data, rep(8'h02));

      // Back-to-back reads: addr 5 (masked lanes) then addr 4 (be=0 write).
      rd_req = 1'b1; rd_addr = 10'd5;
      tick();
      rd_addr = 10'd4;
      chk("b2b_lat1_valid", W'(rd_valid), W'(0));
      tick();
      rd_req = 1'b0;
      chk("b2b_a5_valid", W'(rd_valid), W'(1));
      chk("b2b_a5_data",  rd_data, 72'hFFFFFFFFFFFF00FF00);
      tick();
      chk("b2b_a4_valid", W'(rd_valid), W'(1));
      chk("b2b_a4_data",  rd_data, rep(8'hFF));
      tick();
      chk("b2b_end_valid", W'(rd_valid), W'(0));

      // Bank 1 fill -> both full, writer stalled.
      for (int k = 0; k < 4; k++) begin
         do_write(AW'(k), rep(8'(8'hA0 + k)), 9'h1FF, k == 3);
      end
      chk("both_full", W'(bank_full), W'(2'b11));
      chk("both_wr_ready", W'(wr_ready), W'(0));

      // Held write (bank0 addr 0, last) while stalled; release with a read.
      wr_valid = 1'b1; wr_addr = 10'd0; wr_data = rep(8'h55); wr_be = 9'h1FF; wr_last = 1'b1;
      tick();
      chk("stall_wr_ready", W'(wr_ready), W'(0));
      chk("stall_full",     W'(bank_full), W'(2'b11));
      rd_req = 1'b1; rd_addr = 10'd1; rd_done = 1'b1;
      tick();
      rd_req = 1'b0; rd_done = 1'b0;
      chk("rel_bank_full", W'(bank_full), W'(2'b10));
      chk("rel_wr_ready",  W'(wr_ready),  W'(1));
      chk("rel_rd_avail",  W'(rd_avail),  W'(1));
      chk("rel_lat1_valid", W'(rd_valid), W'(0));
      tick();
      wr_valid = 1'b0; wr_last = 1'b0;
      chk("rel_rd_valid", W'(rd_valid), W'(1));
      chk("rel_rd_data",  rd_data, rep(8'h01));
      chk("held_wr_accepted_full", W'(bank_full), W'(2'b11));
      chk("held_wr_ready", W'(wr_ready), W'(0));

      // rsel now points at bank 1.
      rd_req = 1'b1; rd_addr = 10'd2;
      tick();
      rd_req = 1'b0;
      tick();
      chk("bank1_rd_valid", W'(rd_valid), W'(1));
      chk("bank1_rd_data",  rd_data, rep(8'hA2));
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      chk("rel1_bank_full", W'(bank_full), W'(2'b01));
      rd_req = 1'b1; rd_addr = 10'd0;
      tick();
      rd_req = 1'b0;
      tick();
      chk("held_data_valid", W'(rd_valid), W'(1));
      chk("held_data",       rd_data, rep(8'h55));

      // Out-of-range write and read.
      chk("pre_err", W'(addr_err), W'(0));
      do_write(10'd912, rep(8'hEE), 9'h1FF, 1'b0);
      chk("wr_oor_err", W'(addr_err), W'(1));
      rd_req = 1'b1; rd_addr = 10'd1000;
      tick();
      rd_req = 1'b0;
      tick();
      chk("rd_oor_valid", W'(rd_valid), W'(1));
      chk("rd_oor_data",  rd_data, W'(0));
      tick();
      tick();
      chk("err_sticky", W'(addr_err), W'(1));
      rd_req = 1'b1; rd_addr = 10'd3;
      tick();
      rd_req = 1'b0;
      tick();
      chk("after_oor_data", rd_data, rep(8'h03));

      // Reset one cycle after an accepted read aborts it.
      rd_req = 1'b1; rd_addr = 10'd2;
      tick();
      rd_req = 1'b0;
      RSTn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick();
      RSTn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("midrst_no_valid", W'(rd_valid), W'(0));
      end
      chk("midrst_rd_data", rd_data, W'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
